// File: rtl/apb_i2c_regs.sv
// APB3 register file and transaction sequencer for the I2C core: holds the
// control/address/count/TX registers, launches transfers and captures results.
module apb_i2c_regs #(
    parameter int APB_AW   = 5,
    parameter int APB_WAIT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [APB_AW-1:0] paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              irq,
    output logic              i_ready,
    output logic [15:0]       tx_ctrl,
    output logic [7:0]        tx_apb_addr,
    output logic [7:0]        tx_apb_data_cnt,
    output logic [7:0]        data_out_apb,
    input  logic [7:0]        data_in_apb,
    input  logic [7:0]        status
);

    localparam logic [0:0]  ST_IDLE   = 1'b0;
    localparam logic [0:0]  ST_ACTIVE = 1'b1;

    localparam logic [2:0]  REG_CTRL   = 3'd0;
    localparam logic [2:0]  REG_ADDR   = 3'd1;
    localparam logic [2:0]  REG_CNT    = 3'd2;
    localparam logic [2:0]  REG_TXDATA = 3'd3;
    localparam logic [2:0]  REG_RXDATA = 3'd4;
    localparam logic [2:0]  REG_CMD    = 3'd5;
    localparam logic [2:0]  REG_STATUS = 3'd6;
    localparam logic [2:0]  REG_IRQ    = 3'd7;

    localparam logic [2:0]  WAIT_C    = 3'(APB_WAIT);
    localparam logic [15:0] CTRL_MASK = 16'h37FF;

    logic [2:0]  wait_q, wait_d;
    logic [0:0]  state_q, state_d;
    logic [15:0] ctrl_q, ctrl_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  txd_q, txd_d;
    logic [7:0]  rxd_q, rxd_d;
    logic        rxv_q, rxv_d;
    logic [7:0]  status_q, status_d;
    logic [3:0]  flags_q, flags_d;
    logic [3:0]  en_q, en_d;
    logic        irq_q, irq_d;

    logic        access;
    logic        wr_fire;
    logic        rd_fire;
    logic        wr_err;
    logic        busy;
    logic        mode_ok;
    logic        complete;
    logic [2:0]  sel;
    logic [1:0]  mode;
    logic [7:0]  rise;
    logic [31:0] rd_mux;
    logic        unused_ok;

    assign access  = psel & penable;
    assign pready  = access & (wait_q == WAIT_C);
    assign wr_fire = pready & pwrite;
    assign rd_fire = pready & ~pwrite;
    assign sel     = paddr[4:2];
    assign busy    = (state_q == ST_ACTIVE);
    assign mode    = ctrl_q[13:12];
    assign mode_ok = (mode == 2'b01) || (mode == 2'b10);
    assign rise    = status & ~status_q;

    // Slave mode also ends a transfer on the STOP condition, not only on done.
    assign complete = busy & (rise[3] | ((mode == 2'b01) & rise[0]));

    assign unused_ok = ^{pwdata[31:16], paddr, rise[7:4], rise[2]};

    always_comb begin
        wr_err = 1'b0;
        if (wr_fire) begin
            if (busy && (sel == REG_CTRL || sel == REG_ADDR || sel == REG_CNT))
                wr_err = 1'b1;
            if (sel == REG_CMD && pwdata[0] && (busy || !mode_ok))
                wr_err = 1'b1;
        end
    end

    assign pslverr = wr_err;

    always_comb begin
        wait_d = 3'd0;
        if (access && !pready)
            wait_d = wait_q + 3'd1;
    end

    always_comb begin
        ctrl_d   = ctrl_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        txd_d    = txd_q;
        rxd_d    = rxd_q;
        rxv_d    = rxv_q;
        state_d  = state_q;
        flags_d  = flags_q;
        en_d     = en_q;
        status_d = status;
        irq_d    = |(flags_q & en_q);

        if (wr_fire && !wr_err) begin
            case (sel)
                REG_CTRL:   ctrl_d = pwdata[15:0] & CTRL_MASK;
                REG_ADDR:   addr_d = pwdata[7:0];
                REG_CNT:    cnt_d  = pwdata[7:0];
                REG_TXDATA: txd_d  = pwdata[7:0];
                REG_CMD: begin
                    if (pwdata[0])
                        state_d = ST_ACTIVE;
                    else if (pwdata[1] && busy)
                        state_d = ST_IDLE;
                end
                REG_IRQ: begin
                    flags_d = flags_q & ~pwdata[3:0];
                    en_d    = pwdata[11:8];
                end
                default: ;
            endcase
        end

        if (rd_fire && sel == REG_RXDATA)
            rxv_d = 1'b0;

        // Sets are applied after W1C and read-clear so a coincident event wins.
        flags_d[2] = flags_d[2] | rise[0];
        flags_d[1] = flags_d[1] | rise[1];

        if (complete) begin
            rxd_d      = data_in_apb;
            rxv_d      = 1'b1;
            flags_d[3] = 1'b1;
            if (rxv_q)
                flags_d[0] = 1'b1;
            state_d    = ST_IDLE;
        end
    end

    always_comb begin
        rd_mux = 32'd0;
        case (sel)
            REG_CTRL:   rd_mux = {16'd0, ctrl_q};
            REG_ADDR:   rd_mux = {24'd0, addr_q};
            REG_CNT:    rd_mux = {24'd0, cnt_q};
            REG_TXDATA: rd_mux = {24'd0, txd_q};
            REG_RXDATA: rd_mux = {24'd0, rxd_q};
            REG_STATUS: rd_mux = {22'd0, busy, rxv_q, status_q};
            REG_IRQ:    rd_mux = {20'd0, en_q, 4'd0, flags_q};
            default:    rd_mux = 32'd0;
        endcase
    end

    assign prdata = (access && !pwrite) ? rd_mux : 32'd0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_q   <= 3'd0;
            state_q  <= ST_IDLE;
            ctrl_q   <= 16'd0;
            addr_q   <= 8'd0;
            cnt_q    <= 8'd0;
            txd_q    <= 8'd0;
            rxd_q    <= 8'd0;
            rxv_q    <= 1'b0;
            status_q <= 8'd0;
            flags_q  <= 4'd0;
            en_q     <= 4'd0;
            irq_q    <= 1'b0;
        end else begin
            wait_q   <= wait_d;
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            txd_q    <= txd_d;
            rxd_q    <= rxd_d;
            rxv_q    <= rxv_d;
            status_q <= status_d;
            flags_q  <= flags_d;
            en_q     <= en_d;
            irq_q    <= irq_d;
        end
    end

    assign irq             = irq_q;
    assign i_ready         = (state_q == ST_ACTIVE);
    assign tx_ctrl         = ctrl_q;
    assign tx_apb_addr     = addr_q;
    assign tx_apb_data_cnt = cnt_q;
    assign data_out_apb    = txd_q;

endmodule

// File: tb/tb_apb_i2c_regs.sv
// Bench for apb_i2c_regs: directed scenarios plus randomized traffic checked
// against a register-level reference model of the programmer's view.
module tb_apb_i2c_regs;

    logic        clk = 1'b0;
    logic        rst;
    logic        psel, penable, pwrite;
    logic [4:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready, pslverr, irq, i_ready;
    logic [15:0] tx_ctrl;
    logic [7:0]  tx_apb_addr, tx_apb_data_cnt, data_out_apb;
    logic [7:0]  data_in_apb, status;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    apb_i2c_regs #(.APB_AW(5), .APB_WAIT(2)) dut (
        .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .irq(irq), .i_ready(i_ready), .tx_ctrl(tx_ctrl),
        .tx_apb_addr(tx_apb_addr), .tx_apb_data_cnt(tx_apb_data_cnt),
        .data_out_apb(data_out_apb), .data_in_apb(data_in_apb), .status(status)
    );

    // Reference model: the programmer-visible state
    logic [15:0] m_ctrl;
    logic [7:0]  m_addr, m_cnt, m_tx, m_rx, m_status;
    bit          m_rxv, m_busy;
    logic [3:0]  m_flags, m_en;

    task model_reset();
        m_ctrl = 0; m_addr = 0; m_cnt = 0; m_tx = 0; m_rx = 0; m_status = 0;
        m_rxv = 0; m_busy = 0; m_flags = 0; m_en = 0;
    endtask

    task model_apb(input bit wr, input int idx, input logic [31:0] wd,
                   output logic [31:0] rd, output bit err);
        rd = 32'd0;
        err = 1'b0;
        if (!wr) begin
            case (idx)
                0: rd = {16'd0, m_ctrl};
                1: rd = {24'd0, m_addr};
                2: rd = {24'd0, m_cnt};
                3: rd = {24'd0, m_tx};
                4: begin rd = {24'd0, m_rx}; m_rxv = 1'b0; end
                6: rd = {22'd0, m_busy, m_rxv, m_status};
                7: rd = {20'd0, m_en, 4'd0, m_flags};
                default: rd = 32'd0;
            endcase
        end else begin
            case (idx)
                0: if (m_busy) err = 1'b1; else m_ctrl = wd[15:0] & 16'h37FF;
                1: if (m_busy) err = 1'b1; else m_addr = wd[7:0];
                2: if (m_busy) err = 1'b1; else m_cnt = wd[7:0];
                3: m_tx = wd[7:0];
                5: begin
                    if (wd[0]) begin
                        if (m_busy || m_ctrl[13:12] == 2'b00 || m_ctrl[13:12] == 2'b11)
                            err = 1'b1;
                        else
                            m_busy = 1'b1;
                    end else if (wd[1]) begin
                        m_busy = 1'b0;
                    end
                end
                7: begin m_flags = m_flags & ~wd[3:0]; m_en = wd[11:8]; end
                default: ;
            endcase
        end
    endtask

    task model_status(input logic [7:0] v, input logic [7:0] din);
        logic [7:0] r;
        r = v & ~m_status;
        if (r[1]) m_flags[1] = 1'b1;
        if (r[0]) m_flags[2] = 1'b1;
        if (m_busy && (r[3] || (m_ctrl[13:12] == 2'b01 && r[0]))) begin
            if (m_rxv) m_flags[0] = 1'b1;
            m_rx = din;
            m_rxv = 1'b1;
            m_flags[3] = 1'b1;
            m_busy = 1'b0;
        end
        m_status = v;
    endtask

    task automatic apb(input bit wr, input int idx, input logic [31:0] wd,
                       output logic [31:0] rd, output bit err, output int waits);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = 5'(idx * 4); pwdata = wd;
        @(posedge clk); #1;
        penable = 1'b1;
        waits = 0;
        while (pready !== 1'b1 && waits < 20) begin
            @(posedge clk); #1;
            waits++;
        end
        if (pready !== 1'b1) begin
            failures++;
            $display("FAIL apb_timeout pready=%b required=1", pready);
        end
        rd = prdata;
        err = pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic drive_status(input logic [7:0] v, input logic [7:0] din);
        @(posedge clk); #1;
        status = v;
        data_in_apb = din;
        @(posedge clk); #1;
        model_status(v, din);
    endtask

    task automatic op(input bit wr, input int idx, input logic [31:0] wd,
                      output logic [31:0] rd, output bit err, output logic [31:0] erd, output bit eerr);
        int w;
        apb(wr, idx, wd, rd, err, w);
        model_apb(wr, idx, wd, erd, eerr);
    endtask

    task automatic test_reset();
        logic [31:0] rd, erd; bit err, eerr;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({i_ready, irq, pready, pslverr} !== 4'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b required=0000", {i_ready, irq, pready, pslverr});
        end
        checks++;
        if ({tx_ctrl, tx_apb_addr, tx_apb_data_cnt, data_out_apb} !== 40'd0) begin
            failures++;
            $display("FAIL reset_regs got=%h required=0", {tx_ctrl, tx_apb_addr, tx_apb_data_cnt, data_out_apb});
        end
        checks++;
        if (prdata !== 32'd0) begin
            failures++;
            $display("FAIL reset_prdata got=%h required=0", prdata);
        end
        rst = 1'b1;
        model_reset();
        op(1'b0, 6, 0, rd, err, erd, eerr);
        checks++;
        if (rd !== erd || rd !== 32'd0) begin
            failures++;
            $display("FAIL reset_status_read got=%h required=%h", rd, erd);
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] rd, erd; bit err, eerr; int w;
        apb(1'b1, 0, 32'h2064, rd, err, w);
        model_apb(1'b1, 0, 32'h2064, erd, eerr);
        checks++;
        if (w !== 2) begin
            failures++;
            $display("FAIL wait_cycles got=%0d required=2", w);
        end
        checks++;
        if (tx_ctrl !== 16'h2064 || err !== 1'b0) begin
            failures++;
            $display("FAIL ctrl_write got=%h err=%b required=2064 err=0", tx_ctrl, err);
        end
    endtask

    task automatic test_master();
        logic [31:0] rd, erd; bit err, eerr;
        op(1'b1, 1, 32'hA0, rd, err, erd, eerr);
        op(1'b1, 2, 32'h01, rd, err, erd, eerr);
        checks++;
        if (tx_apb_addr !== 8'hA0 || tx_apb_data_cnt !== 8'h01) begin
            failures++;
            $display("FAIL addr_cnt got=%h/%h required=a0/01", tx_apb_addr, tx_apb_data_cnt);
        end
        op(1'b1, 5, 32'h1, rd, err, erd, eerr);
        checks++;
        if (i_ready !== 1'b1 || err !== 1'b0) begin
            failures++;
            $display("FAIL start_ready got=%b err=%b required=1 err=0", i_ready, err);
        end
        drive_status(8'h08, 8'h5A);
        checks++;
        if (i_ready !== 1'b0) begin
            failures++;
            $display("FAIL done_ready got=%b required=0", i_ready);
        end
        drive_status(8'h00, 8'h00);
        op(1'b0, 4, 0, rd, err, erd, eerr);
        checks++;
        if (rd !== 32'h5A) begin
            failures++;
            $display("FAIL rxdata got=%h required=5a", rd);
        end
        op(1'b0, 7, 0, rd, err, erd, eerr);
        checks++;
        if (rd[3] !== 1'b1 || rd !== erd) begin
            failures++;
            $display("FAIL done_flag got=%h required=%h", rd, erd);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd, erd; bit err, eerr;
        op(1'b1, 5, 32'h1, rd, err, erd, eerr);
        op(1'b1, 5, 32'h1, rd, err, erd, eerr);
        checks++;
        if (err !== 1'b1 || i_ready !== 1'b1) begin
            failures++;
            $display("FAIL start_busy err=%b i_ready=%b required err=1 i_ready=1", err, i_ready);
        end
        op(1'b1, 0, 32'h1000, rd, err, erd, eerr);
        checks++;
        if (err !== 1'b1 || tx_ctrl !== 16'h2064) begin
            failures++;
            $display("FAIL ctrl_busy err=%b tx_ctrl=%h required err=1 tx_ctrl=2064", err, tx_ctrl);
        end
        op(1'b1, 5, 32'h2, rd, err, erd, eerr);
        checks++;
        if (i_ready !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL abort got i_ready=%b err=%b required 0/0", i_ready, err);
        end
        op(1'b1, 0, 32'h0064, rd, err, erd, eerr);
        op(1'b1, 5, 32'h1, rd, err, erd, eerr);
        checks++;
        if (err !== 1'b1 || i_ready !== 1'b0) begin
            failures++;
            $display("FAIL start_mode0 err=%b i_ready=%b required err=1 i_ready=0", err, i_ready);
        end
        op(1'b1, 0, 32'h2064, rd, err, erd, eerr);
    endtask

    task automatic test_abort_no_flag();
        logic [31:0] rd, erd; bit err, eerr;
        op(1'b1, 7, 32'h0000000F, rd, err, erd, eerr);
        op(1'b1, 5, 32'h1, rd, err, erd, eerr);
        op(1'b1, 5, 32'h2, rd, err, erd, eerr);
        op(1'b0, 7, 0, rd, err, erd, eerr);
        checks++;
        if (rd !== erd || rd[3] !== 1'b0 || i_ready !== 1'b0) begin
            failures++;
            $display("FAIL abort_flags got=%h i_ready=%b required=%h i_ready=0", rd, i_ready, erd);
        end
    endtask

    task automatic test_overrun();
        logic [31:0] rd, erd; bit err, eerr;
        op(1'b0, 4, 0, rd, err, erd, eerr);
        op(1'b1, 7, 32'h0000000F, rd, err, erd, eerr);
        op(1'b1, 5, 32'h1, rd, err, erd, eerr);
        drive_status(8'h08, 8'h11);
        drive_status(8'h00, 8'h00);
        op(1'b1, 5, 32'h1, rd, err, erd, eerr);
        drive_status(8'h08, 8'h22);
        drive_status(8'h00, 8'h00);
        op(1'b0, 7, 0, rd, err, erd, eerr);
        checks++;
        if (rd[0] !== 1'b1 || rd[3] !== 1'b1 || rd !== erd) begin
            failures++;
            $display("FAIL ovr_flag got=%h required=%h", rd, erd);
        end
        op(1'b0, 4, 0, rd, err, erd, eerr);
        checks++;
        if (rd !== 32'h22) begin
            failures++;
            $display("FAIL ovr_rxdata got=%h required=22", rd);
        end
    endtask

    task automatic test_w1c_race();
        logic [31:0] rd, erd; bit err, eerr; int w;
        op(1'b1, 7, 32'h0000080F, rd, err, erd, eerr);
        op(1'b1, 5, 32'h1, rd, err, erd, eerr);
        drive_status(8'h08, 8'h33);
        drive_status(8'h00, 8'h00);
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL irq_done got=%b required=1", irq);
        end
        op(1'b1, 5, 32'h1, rd, err, erd, eerr);
        // W1C of done lands on the same edge as a fresh done rise
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 5'(7 * 4); pwdata = 32'h808;
        @(posedge clk); #1;
        penable = 1'b1;
        w = 0;
        while (pready !== 1'b1 && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        status = 8'h08;
        data_in_apb = 8'h44;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        model_apb(1'b1, 7, 32'h808, erd, eerr);
        model_status(8'h08, 8'h44);
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL race_irq0 got=%b required=1", irq);
        end
        @(posedge clk); #1;
        checks++;
        if (irq !== 1'b1 || i_ready !== 1'b0) begin
            failures++;
            $display("FAIL race_irq1 irq=%b i_ready=%b required irq=1 i_ready=0", irq, i_ready);
        end
        drive_status(8'h00, 8'h00);
        op(1'b0, 7, 0, rd, err, erd, eerr);
        checks++;
        if (rd[3] !== 1'b1 || rd !== erd) begin
            failures++;
            $display("FAIL race_flag got=%h required=%h", rd, erd);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, erd; bit err, eerr;
        op(1'b1, 5, 32'h1, rd, err, erd, eerr);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({i_ready, irq, tx_ctrl, tx_apb_addr, tx_apb_data_cnt, data_out_apb} !== 42'd0) begin
            failures++;
            $display("FAIL reset_mid got=%h required=0",
                     {i_ready, irq, tx_ctrl, tx_apb_addr, tx_apb_data_cnt, data_out_apb});
        end
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, wd; bit err, eerr, wr; int idx, kind;
        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 5);
            if (kind == 4) begin
                drive_status(8'($urandom & 32'h0F), 8'($urandom));
            end else begin
                wr = 1'b1;
                idx = 5;
                wd = $urandom;
                case (kind)
                    0: idx = $urandom_range(0, 7);
                    1: begin wr = 1'b0; idx = $urandom_range(0, 7); end
                    2: wd = 32'h1;
                    3: wd = 32'h2;
                    default: begin
                        idx = 0;
                        wd = ($urandom & 32'h07FF) | (32'($urandom_range(1, 2)) << 12);
                    end
                endcase
                op(wr, idx, wd, rd, err, erd, eerr);
                checks++;
                if (err !== eerr || (!wr && rd !== erd)) begin
                    failures++;
                    $display("FAIL rand_apb n=%0d idx=%0d wr=%b got rd=%h err=%b required rd=%h err=%b",
                             n, idx, wr, rd, err, erd, eerr);
                end
            end
            @(posedge clk); #1;
            checks++;
            if (i_ready !== m_busy || irq !== |(m_flags & m_en) || tx_ctrl !== m_ctrl ||
                tx_apb_addr !== m_addr || tx_apb_data_cnt !== m_cnt || data_out_apb !== m_tx) begin
                failures++;
                $display("FAIL rand_out n=%0d got rdy=%b irq=%b ctrl=%h a=%h c=%h t=%h required rdy=%b irq=%b ctrl=%h a=%h c=%h t=%h",
                         n, i_ready, irq, tx_ctrl, tx_apb_addr, tx_apb_data_cnt, data_out_apb,
                         m_busy, |(m_flags & m_en), m_ctrl, m_addr, m_cnt, m_tx);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 5'd0; pwdata = 32'd0; data_in_apb = 8'd0; status = 8'd0;
        model_reset();
        test_reset();
        test_wait_states();
        test_master();
        test_errors();
        test_abort_no_flag();
        test_overrun();
        test_w1c_race();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
